// File: rtl/branch_fu_pkg.sv
// Shared types for the branch functional unit:
// CPU widths, branch op encoding and pipeline bundles.
package branch_fu_pkg;

  localparam int ROB_IDX = 5;
  localparam int PRF_IDX = 6;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } br_op_t;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [31:0]        pc;
    logic [31:0]        rs1;
    logic [31:0]        rs2;
    logic [31:0]        imm;
    br_op_t             op;
    logic               pred_taken;
    logic [31:0]        pred_target;
    logic [PRF_IDX-1:0] rd_phy;
  } s1_entry_t;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic               miss;
    logic [31:0]        next_pc;
    logic               wr_rd;
    logic [PRF_IDX-1:0] rd_phy;
    logic [31:0]        link;
  } s2_entry_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch resolver:
// direction and target for one branch/jump uop.
module branch_compare
  import branch_fu_pkg::*;
(
  input  br_op_t      op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] imm_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] jalr_sum;

  assign jalr_sum = rs1_i + imm_i;

  always_comb begin
    taken_o  = 1'b0;
    target_o = pc_i + imm_i;
    unique case (op_i)
      BEQ:  taken_o = (rs1_i == rs2_i);
      BNE:  taken_o = (rs1_i != rs2_i);
      BLT:  taken_o = ($signed(rs1_i) < $signed(rs2_i));
      BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      BLTU: taken_o = (rs1_i < rs2_i);
      BGEU: taken_o = (rs1_i >= rs2_i);
      JAL:  taken_o = 1'b1;
      JALR: begin
        taken_o  = 1'b1;
        target_o = {jalr_sum[31:1], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/branch_fu.sv
// Two-stage branch unit: S1 holds the issued uop,
// S2 holds the resolution until its CDB slot retires it.
module branch_fu
  import branch_fu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [ROB_IDX-1:0] issue_rob_id,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_rs1_v,
  input  logic [31:0]        issue_rs2_v,
  input  logic [31:0]        issue_imm,
  input  logic [2:0]         issue_br_op,
  input  logic               issue_pred_taken,
  input  logic [31:0]        issue_pred_target,
  input  logic [PRF_IDX-1:0] issue_rd_phy,
  input  logic               flush,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [PRF_IDX-1:0] cdb_rd_phy,
  output logic [31:0]        cdb_rd_v,
  output logic               br_cdb_valid,
  output logic [ROB_IDX-1:0] br_cdb_rob_id,
  output logic               br_cdb_miss_predict,
  output logic [31:0]        br_cdb_target_address
);

  s1_entry_t   s1_q, s1_d;
  s2_entry_t   s2_q, s2_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic        live, accept;
  logic        s1_adv, s2_done;
  logic        taken;
  logic [31:0] target;

  assign live    = rst_n & ~flush;
  assign s2_done = s2_valid_q & (~s2_q.wr_rd | cdb_ready);
  assign s1_adv  = s1_valid_q & (~s2_valid_q | s2_done);

  assign issue_ready = live & (~s1_valid_q | s1_adv);
  assign accept      = issue_valid & issue_ready;

  always_comb begin
    s1_d.rob_id      = issue_rob_id;
    s1_d.pc          = issue_pc;
    s1_d.rs1         = issue_rs1_v;
    s1_d.rs2         = issue_rs2_v;
    s1_d.imm         = issue_imm;
    s1_d.op          = br_op_t'(issue_br_op);
    s1_d.pred_taken  = issue_pred_taken;
    s1_d.pred_target = issue_pred_target;
    s1_d.rd_phy      = issue_rd_phy;
  end

  branch_compare u_cmp (
    .op_i     (s1_q.op),
    .pc_i     (s1_q.pc),
    .rs1_i    (s1_q.rs1),
    .rs2_i    (s1_q.rs2),
    .imm_i    (s1_q.imm),
    .taken_o  (taken),
    .target_o (target)
  );

  always_comb begin
    s2_d.rob_id  = s1_q.rob_id;
    s2_d.rd_phy  = s1_q.rd_phy;
    s2_d.link    = s1_q.pc + 32'd4;
    s2_d.next_pc = taken ? target : s2_d.link;
    s2_d.wr_rd   = ((s1_q.op == JAL) || (s1_q.op == JALR))
                 && (s1_q.rd_phy != '0);
    s2_d.miss    = (taken != s1_q.pred_taken)
                 || (taken && (target != s1_q.pred_target));
  end

  assign s1_valid_d = accept | (s1_valid_q & ~s1_adv);
  assign s2_valid_d = s1_adv | (s2_valid_q & ~s2_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Payload is never reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (accept)
      s1_q <= s1_d;
    if (live && s1_adv)
      s2_q <= s2_d;
  end

  assign cdb_valid  = live & s2_valid_q & s2_q.wr_rd;
  assign cdb_rd_phy = s2_q.rd_phy;
  assign cdb_rd_v   = s2_q.link;

  assign br_cdb_valid          = live & s2_done;
  assign br_cdb_rob_id         = s2_q.rob_id;
  assign br_cdb_miss_predict   = s2_q.miss;
  assign br_cdb_target_address = s2_q.next_pc;

endmodule
